// File: rtl/key_debounce_pkg.sv
// Shared event-code constants for the keypad debouncer and its consumers.
// Every consumer decodes EVT_CODE against these values.
package key_debounce_pkg;

    localparam int NUM_MAIN  = 9;
    localparam int NUM_LEFT  = 4;
    localparam int KEY_BASE  = 0;
    localparam int LEFT_BASE = 9;
    localparam int NUM_KEYS  = 13;
    localparam int CODE_W    = 4;

    typedef logic [CODE_W-1:0]   evt_code_t;
    typedef logic [NUM_KEYS-1:0] key_vec_t;

    function automatic evt_code_t lowest_idx(key_vec_t v);
        evt_code_t idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = CODE_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_filter.sv
// Single-key debouncer: 2-flop synchronizer, tick-driven hold counter,
// accepted level and a one-cycle pulse on each accepted press.
module key_filter #(
    parameter int DEB_TICKS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic press
);

    localparam logic [3:0] CNT_MAX = 4'(DEB_TICKS - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic [3:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       press_q, press_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (tick) begin
            if (sync2_q != level_q) begin
                if (cnt_q == CNT_MAX) begin
                    level_d = ~level_q;
                    cnt_d   = '0;
                    press_d = ~level_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/key_debounce.sv
// Keypad debouncer: shared prescaler, 13 key filters, pending-press
// vector and a small event FIFO with a sticky lost-press flag.
import key_debounce_pkg::*;

module key_debounce #(
    parameter int TICK_CYCLES = 24000,
    parameter int DEB_TICKS   = 10,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NUM_MAIN-1:0] KEY,
    input  logic [NUM_LEFT-1:0] LEFT_KEY,
    output logic [NUM_MAIN-1:0] KEY_LEVEL,
    output logic [NUM_LEFT-1:0] LEFT_LEVEL,
    output logic [NUM_MAIN-1:0] KEY_PRESS,
    output logic [NUM_LEFT-1:0] LEFT_PRESS,
    output logic                EVT_VALID,
    output logic [CODE_W-1:0]   EVT_CODE,
    input  logic                EVT_READY,
    output logic                EVT_OVF
);

    localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;

    key_vec_t raw_all, level_all, press_all;

    assign raw_all[KEY_BASE +: NUM_MAIN]  = KEY;
    assign raw_all[LEFT_BASE +: NUM_LEFT] = LEFT_KEY;

    assign tick  = (pre_q == PRE_W'(TICK_CYCLES - 1));
    assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_filt
        key_filter #(
            .DEB_TICKS(DEB_TICKS)
        ) u_filt (
            .clk  (CLK),
            .reset(RESET),
            .raw  (raw_all[i]),
            .tick (tick),
            .level(level_all[i]),
            .press(press_all[i])
        );
    end

    assign KEY_LEVEL  = level_all[KEY_BASE +: NUM_MAIN];
    assign LEFT_LEVEL = level_all[LEFT_BASE +: NUM_LEFT];
    assign KEY_PRESS  = press_all[KEY_BASE +: NUM_MAIN];
    assign LEFT_PRESS = press_all[LEFT_BASE +: NUM_LEFT];

    key_vec_t         pend_q, pend_d, clr;
    logic             ovf_q, ovf_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    evt_code_t        mem_q [FIFO_DEPTH];
    logic             full, empty, pop, wr_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = ~empty & EVT_READY;
    assign wr_en = (|pend_q) & (~full | pop);

    always_comb begin
        clr      = wr_en ? (pend_q & (~pend_q + key_vec_t'(1))) : '0;
        // a press on a bit leaving this cycle simply re-arms it
        pend_d   = (pend_q & ~clr) | press_all;
        ovf_d    = ovf_q | (|(press_all & pend_q & ~clr));
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pre_q    <= '0;
            pend_q   <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            pre_q    <= pre_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= lowest_idx(pend_q);
    end

    assign EVT_VALID = ~empty;
    assign EVT_CODE  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign EVT_OVF   = ovf_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with TICK_CYCLES=10, DEB_TICKS=4.
// Expected cycle numbers are counted from the last reset edge.
module tb_key_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] key;
    logic [3:0] left_key;
    logic [8:0] key_level, key_press;
    logic [3:0] left_level, left_press;
    logic       evt_valid, evt_ready, evt_ovf;
    logic [3:0] evt_code;

    int errors = 0;
    int checks = 0;
    int k      = 0;
    int npress = 0;
    int lvl_hi = 0;

    key_debounce #(
        .TICK_CYCLES(10),
        .DEB_TICKS  (4),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .KEY       (key),
        .LEFT_KEY  (left_key),
        .KEY_LEVEL (key_level),
        .LEFT_LEVEL(left_level),
        .KEY_PRESS (key_press),
        .LEFT_PRESS(left_press),
        .EVT_VALID (evt_valid),
        .EVT_CODE  (evt_code),
        .EVT_READY (evt_ready),
        .EVT_OVF   (evt_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        npress += $countones({left_press, key_press});
        if (key_level[0]) lvl_hi++;
    endtask

    task automatic run_to(input int target);
        while (k < target) begin
            step();
            k++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        k = 0;
        npress = 0;
        lvl_hi = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_lvl"}, 32'({left_level, key_level}), 32'd0);
        chk({tag, "_prs"}, 32'({left_press, key_press}), 32'd0);
        chk({tag, "_vld"}, 32'(evt_valid), 32'd0);
        chk({tag, "_code"}, 32'(evt_code), 32'd0);
        chk({tag, "_ovf"}, 32'(evt_ovf), 32'd0);
    endtask

    initial begin
        logic [3:0] exp6 [6];
        logic [3:0] exp5 [5];
        exp6 = '{4'd6, 4'd9, 4'd1, 4'd4, 4'd7, 4'd11};
        exp5 = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd2};

        rst = 1'b1;
        key = '0;
        left_key = '0;
        evt_ready = 1'b0;
        repeat (3) step();
        chk_all_zero("rst");

        // reset during debounce (two ticks counted on KEY[5])
        rst = 1'b0;
        k = 0;
        npress = 0;
        key = 9'h020;
        run_to(25);
        chk("mid_lvl", 32'(key_level), 32'd0);
        chk("mid_prs", 32'(npress), 32'd0);
        do_reset();
        chk_all_zero("midrst");
        run_to(39);
        chk("r5_lvl39", 32'(key_level), 32'd0);
        run_to(40);
        chk("r5_prs40", 32'(key_press), 32'h020);
        chk("r5_lvl40", 32'(key_level), 32'h020);
        run_to(41);
        chk("r5_prs41", 32'(key_press), 32'd0);
        run_to(42);
        chk("r5_vld42", 32'(evt_valid), 32'd1);
        chk("r5_code42", 32'(evt_code), 32'd5);
        chk("r5_npress", 32'(npress), 32'd1);

        // KEY[3] held 60 cycles
        key = '0;
        do_reset();
        key = 9'h008;
        run_to(39);
        chk("k3_lvl39", 32'(key_level), 32'd0);
        run_to(40);
        chk("k3_prs40", 32'(key_press), 32'h008);
        chk("k3_lvl40", 32'(key_level), 32'h008);
        chk("k3_vld40", 32'(evt_valid), 32'd0);
        run_to(41);
        chk("k3_vld41", 32'(evt_valid), 32'd0);
        run_to(42);
        chk("k3_vld42", 32'(evt_valid), 32'd1);
        chk("k3_code42", 32'(evt_code), 32'd3);
        run_to(60);
        chk("k3_npress", 32'(npress), 32'd1);
        chk("k3_hold", 32'(evt_code), 32'd3);
        key = '0;
        evt_ready = 1'b1;
        run_to(61);
        chk("k3_pop", 32'(evt_valid), 32'd0);
        run_to(121);
        chk("k3_rel_lvl", 32'(key_level), 32'd0);
        chk("k3_rel_prs", 32'(npress), 32'd1);
        chk("k3_rel_vld", 32'(evt_valid), 32'd0);

        // KEY[0] bouncing every 25 cycles
        evt_ready = 1'b0;
        do_reset();
        for (int t = 0; t < 200; t++) begin
            if (t % 25 == 0) key[0] = ~key[0];
            run_to(t + 1);
        end
        chk("bnc_lvl", 32'(lvl_hi), 32'd0);
        chk("bnc_prs", 32'(npress), 32'd0);
        chk("bnc_vld", 32'(evt_valid), 32'd0);

        // simultaneous KEY[8] and LEFT_KEY[1]
        key = '0;
        evt_ready = 1'b1;
        do_reset();
        key = 9'h100;
        left_key = 4'b0010;
        run_to(40);
        chk("sim_kp", 32'(key_press), 32'h100);
        chk("sim_lp", 32'(left_press), 32'h2);
        run_to(42);
        chk("sim_v42", 32'(evt_valid), 32'd1);
        chk("sim_c42", 32'(evt_code), 32'd8);
        run_to(43);
        chk("sim_v43", 32'(evt_valid), 32'd1);
        chk("sim_c43", 32'(evt_code), 32'd10);
        run_to(44);
        chk("sim_v44", 32'(evt_valid), 32'd0);

        // six presses into a 4-deep FIFO with the consumer stalled
        key = '0;
        left_key = '0;
        evt_ready = 1'b0;
        do_reset();
        key = 9'h040;
        left_key = 4'b0001;
        run_to(50);
        key = 9'h0d2;
        left_key = 4'b0101;
        run_to(95);
        chk("q6_c95", 32'(evt_code), 32'd6);
        run_to(100);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("q6_v%0d", i), 32'(evt_valid), 32'd1);
            chk($sformatf("q6_c%0d", i), 32'(evt_code), 32'(exp6[i]));
            evt_ready = 1'b1;
            run_to(101 + i);
        end
        chk("q6_empty", 32'(evt_valid), 32'd0);
        chk("q6_ovf", 32'(evt_ovf), 32'd0);

        // duplicate KEY[2] press while its pending bit is held
        key = '0;
        left_key = '0;
        evt_ready = 1'b0;
        do_reset();
        key = 9'h01b;
        run_to(50);
        chk("ov_c50", 32'(evt_code), 32'd0);
        key[2] = 1'b1;
        run_to(100);
        key[2] = 1'b0;
        run_to(150);
        chk("ov_lvl150", 32'(key_level[2]), 32'd0);
        key[2] = 1'b1;
        run_to(190);
        chk("ov_prs190", 32'(key_press), 32'h004);
        chk("ov_f190", 32'(evt_ovf), 32'd0);
        run_to(191);
        chk("ov_f191", 32'(evt_ovf), 32'd1);
        run_to(200);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ov_c%0d", i), 32'(evt_code), 32'(exp5[i]));
            evt_ready = 1'b1;
            run_to(201 + i);
        end
        chk("ov_empty", 32'(evt_valid), 32'd0);
        run_to(230);
        chk("ov_sticky", 32'(evt_ovf), 32'd1);
        key = '0;
        do_reset();
        chk("ov_clr", 32'(evt_ovf), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The module SHALL have parameter TICK_CYCLES, default 24000, giving the number of CLK cycles per sample tick (1 ms at 24 MHz).
REQ-002 The module SHALL have parameter DEB_TICKS, default 10, giving the number of consecutive ticks a new level must hold before it is accepted; legal range 2..15.
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 4, giving the number of event FIFO entries; must be a power of 2.
REQ-004 Port CLK, input, 1 bit: the single clock (24 MHz system clock).
REQ-005 Port RESET, input, 1 bit: synchronous, active-high reset.
REQ-006 Port KEY, input, 9 bits: raw asynchronous keypad keys, 1 = pressed.
REQ-007 Port LEFT_KEY, input, 4 bits: raw asynchronous left keys, 1 = pressed.
REQ-008 Port KEY_LEVEL, output, 9 bits: debounced KEY levels.
REQ-009 Port LEFT_LEVEL, output, 4 bits: debounced LEFT_KEY levels.
REQ-010 Port KEY_PRESS, output, 9 bits: one-cycle pulse on each debounced 0->1 edge of KEY.
REQ-011 Port LEFT_PRESS, output, 4 bits: one-cycle pulse on each debounced 0->1 edge of LEFT_KEY.
REQ-012 Port EVT_VALID, output, 1 bit: the event FIFO is non-empty.
REQ-013 Port EVT_CODE, output, 4 bits: head event code; KEY[i] = i (0..8), LEFT_KEY[j] = 9+j (9..12).
REQ-014 Port EVT_READY, input, 1 bit: the consumer accepts the head event.
REQ-015 Port EVT_OVF, output, 1 bit: sticky flag indicating a press was lost.

Function
REQ-016 Every raw input bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-017 A free-running prescaler SHALL count 0..TICK_CYCLES-1 and assert an internal tick for one cycle at TICK_CYCLES-1, then wrap to 0.
REQ-018 Each of the 13 keys SHALL have its own 4-bit counter; on a tick where the synchronized sample differs from the level, the counter SHALL increment, and on a tick where they are equal it SHALL clear.
REQ-019 When the counter reaches DEB_TICKS-1 and the sample still differs on a tick, the level SHALL toggle at that edge and the counter SHALL clear; a glitch shorter than DEB_TICKS ticks SHALL never change the level.
REQ-020 The PRESS bit SHALL be registered at the same edge as the 0->1 level change and SHALL be high for exactly one cycle; a release generates no PRESS and no event.
REQ-021 A PRESS SHALL set the key's bit in a 13-bit pending vector at the next edge.
REQ-022 Each cycle in which the FIFO can accept a write, the lowest-indexed pending bit SHALL be written as its code and cleared; at most one write SHALL occur per cycle.
REQ-023 The FIFO can accept a write when it is not full, or when it is full and a pop occurs in the same cycle.
REQ-024 Latency: with an empty FIFO and no other pending keys, EVT_VALID SHALL rise 2 cycles after the PRESS pulse cycle.
REQ-025 A pop SHALL occur on every edge where EVT_VALID and EVT_READY are both high; EVT_CODE SHALL be stable while EVT_VALID is high and EVT_READY is low.
REQ-026 When the FIFO is full, pending bits SHALL be held without loss.
REQ-027 If a PRESS arrives for a key whose pending bit is already set, EVT_OVF SHALL be set and the duplicate discarded.
REQ-028 EVT_OVF SHALL remain set until reset.
REQ-029 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap naturally; full = MSBs differ and LSBs equal; empty = pointers equal.

Reset
REQ-030 When RESET is high at an edge, the following SHALL clear to 0: synchronizers, prescaler, counters, levels, PRESS outputs, pending vector, FIFO pointers, EVT_VALID and EVT_OVF.
REQ-031 EVT_CODE SHALL read 0 during and after reset.
REQ-032 A key held through reset release SHALL produce a PRESS only after DEB_TICKS full ticks.
REQ-033 Reset in the middle of debounce or during a handshake SHALL abort it without emitting a partial event.

Structure
REQ-034 A shared package SHALL hold the event-code constants (KEY_BASE = 0, LEFT_BASE = 9, NUM_KEYS = 13) and the code width 4, so that the consumers (led_ctrl, segment, dot, textlcd, motor, piezo) decode identically.
REQ-035 One sub-module, key_filter (synchronizer + counter + level + edge for a single bit), SHALL be instantiated 13 times.
REQ-036 The prescaler, pending logic and FIFO SHALL remain in key_debounce.

Verification
REQ-037 Scenarios SHALL use TICK_CYCLES = 10 and DEB_TICKS = 4.
REQ-038 Hold KEY[3] high for 60 cycles -> KEY_LEVEL[3] rises after 4 ticks, one KEY_PRESS[3] pulse, EVT_VALID rises 2 cycles later with EVT_CODE = 3.
REQ-039 Toggle KEY[0] every 25 cycles -> KEY_LEVEL[0] stays 0 and no event is produced.
REQ-040 Press LEFT_KEY[1] and KEY[8] in the same cycle with EVT_READY = 1 -> events 8 then 10 on consecutive cycles.
REQ-041 Hold EVT_READY = 0 and press 6 distinct keys -> 4 queued, 2 held pending; then raise EVT_READY -> all 6 codes delivered in press order with lowest index first on ties, and EVT_OVF = 0.
REQ-042 Hold EVT_READY = 0, then press and release KEY[2], then press it again after the FIFO is full -> EVT_OVF = 1 and it stays 1 until RESET.
REQ-043 Assert RESET for 1 cycle while KEY[5] is mid-debounce (2 ticks counted) -> all outputs 0, and the PRESS occurs only 4 full ticks after reset release.
